// File: rtl/rpsd_arb.sv
`default_nettype none
// ============================================================================
// Module      : rpsd_arb
// Description : Round-robin arbiter granting one of eight drives access to a
//               shared SD controller. A scan pointer walks the drives one per
//               clock; a requesting drive is latched (op + LSA) and presented
//               to the controller until it reports completion, then the drive
//               gets a one-cycle acknowledge and is given a bounded window to
//               drop its request before scanning resumes at the next unit.
// Ports       : clk, rst (async, active-high), clr (sync device clear)
//               rpSDREQ/rpSDOP/rpSDLSA - per-drive request, op, sector address
//               sdREQ/sdOP/sdLSA/sdSCAN - request to controller, granted unit
//               sdDONE                  - completion pulse from controller
//               rpSDACK                 - per-drive one-hot acknowledge
//               arbBUSY/arbTMO          - busy status, sticky hold timeout
// Revision    : 1.0 - initial release
// ============================================================================
module rpsd_arb #(
    parameter int HOLDMAX = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [7:0]   rpSDREQ,
    input  logic [23:0]  rpSDOP,
    input  logic [167:0] rpSDLSA,
    output logic         sdREQ,
    output logic [2:0]   sdOP,
    output logic [20:0]  sdLSA,
    output logic [2:0]   sdSCAN,
    input  logic         sdDONE,
    output logic [7:0]   rpSDACK,
    output logic         arbBUSY,
    output logic         arbTMO
);

    localparam logic [1:0] ST_SCAN    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_ACK     = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic [10:0] HOLD_LIMIT = 11'(HOLDMAX);

    logic [1:0]  state;
    logic [1:0]  next_state;
    logic [10:0] hold_cnt;
    logic        req_cur;
    logic [2:0]  op_cur;
    logic [20:0] lsa_cur;
    logic        hold_expired;

    // Select the slices belonging to the unit under the scan pointer.
    always_comb begin
        req_cur = 1'b0;
        op_cur  = 3'd0;
        lsa_cur = 21'd0;
        for (int n = 0; n < 8; n++) begin
            if (sdSCAN == 3'(n)) begin
                req_cur = rpSDREQ[n];
                op_cur  = rpSDOP[3*n +: 3];
                lsa_cur = rpSDLSA[21*n +: 21];
            end
        end
    end

    assign hold_expired = (hold_cnt == HOLD_LIMIT);

    // State register. sdREQ is registered alongside the state so that it is
    // high for exactly the cycles spent in BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_SCAN;
            sdREQ <= 1'b0;
        end else if (clr) begin
            state <= ST_SCAN;
            sdREQ <= 1'b0;
        end else begin
            state <= next_state;
            sdREQ <= (next_state == ST_BUSY);
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_SCAN:    if (req_cur) next_state = ST_BUSY;
            ST_BUSY:    if (sdDONE)  next_state = ST_ACK;
            ST_ACK:     next_state = ST_RELEASE;
            ST_RELEASE: if (!req_cur || hold_expired) next_state = ST_SCAN;
            default:    next_state = ST_SCAN;
        endcase
    end

    // Outputs decoded from the state register only, so an asynchronous reset
    // clears them immediately.
    always_comb begin
        arbBUSY = (state != ST_SCAN);
        rpSDACK = 8'h00;
        if (state == ST_ACK) begin
            rpSDACK = 8'h01 << sdSCAN;
        end
    end

    // Scan pointer, latched operation, hold counter and timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdSCAN   <= 3'd0;
            sdOP     <= 3'd0;
            sdLSA    <= 21'd0;
            hold_cnt <= 11'd0;
            arbTMO   <= 1'b0;
        end else if (clr) begin
            sdSCAN   <= 3'd0;
            sdOP     <= 3'd0;
            sdLSA    <= 21'd0;
            hold_cnt <= 11'd0;
            arbTMO   <= 1'b0;
        end else begin
            case (state)
                ST_SCAN: begin
                    if (req_cur) begin
                        sdOP  <= op_cur;
                        sdLSA <= lsa_cur;
                    end else begin
                        sdSCAN <= sdSCAN + 3'd1;
                    end
                end
                ST_ACK: begin
                    hold_cnt <= 11'd0;
                end
                ST_RELEASE: begin
                    if (!req_cur || hold_expired) begin
                        // Advancing past the served unit gives round-robin order.
                        sdSCAN <= sdSCAN + 3'd1;
                        if (req_cur) begin
                            arbTMO <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 11'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rpsd_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_rpsd_arb
// Description : Self-checking bench for rpsd_arb. Expected grants (unit, op,
//               LSA) are queued when requests are raised and compared when the
//               arbiter presents sdREQ.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rpsd_arb;

    localparam int HOLDMAX = 15;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         clr = 1'b0;
    logic [7:0]   rpSDREQ = 8'h00;
    logic [23:0]  rpSDOP = 24'h0;
    logic [167:0] rpSDLSA = 168'h0;
    logic         sdDONE = 1'b0;
    logic         sdREQ;
    logic [2:0]   sdOP;
    logic [20:0]  sdLSA;
    logic [2:0]   sdSCAN;
    logic [7:0]   rpSDACK;
    logic         arbBUSY;
    logic         arbTMO;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]  unit;
        logic [2:0]  op;
        logic [20:0] lsa;
    } grant_t;

    grant_t exp_q[$];

    rpsd_arb #(.HOLDMAX(HOLDMAX)) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .rpSDREQ (rpSDREQ),
        .rpSDOP  (rpSDOP),
        .rpSDLSA (rpSDLSA),
        .sdREQ   (sdREQ),
        .sdOP    (sdOP),
        .sdLSA   (sdLSA),
        .sdSCAN  (sdSCAN),
        .sdDONE  (sdDONE),
        .rpSDACK (rpSDACK),
        .arbBUSY (arbBUSY),
        .arbTMO  (arbTMO)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int unit);
        grant_t g;
        g.unit = 3'(unit);
        g.op   = rpSDOP[3*unit +: 3];
        g.lsa  = rpSDLSA[21*unit +: 21];
        exp_q.push_back(g);
    endtask

    // Wait (bounded) for a grant, pop the expected entry and compare.
    task automatic grab(output grant_t e, output bit ok);
        ok = 1'b0;
        e  = '0;
        for (int i = 0; i < 40; i++) begin
            if (sdREQ) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            check_val("grant_timeout", 32'd0, 32'd1);
        end
        if (exp_q.size() == 0) begin
            check_val("sb_empty", 32'd0, 32'd1);
            ok = 1'b0;
            return;
        end
        e = exp_q.pop_front();
        if (!ok) return;
        check_val("grant_unit", 32'(sdSCAN), 32'(e.unit));
        check_val("grant_op",   32'(sdOP),   32'(e.op));
        check_val("grant_lsa",  32'(sdLSA),  32'(e.lsa));
    endtask

    // Serve one grant: verify latching, complete it, check the ack pulse and,
    // when drop is set, release the request right after the ack.
    task automatic serve(input bit drop);
        grant_t     e;
        bit         ok;
        logic [7:0] oh;
        logic [2:0] nx;
        grab(e, ok);
        if (!ok) return;
        // Disturb the granted drive's op; the latched copy must not follow.
        rpSDOP[3*e.unit +: 3] = ~e.op;
        tick();
        tick();
        check_val("hold_req",  32'(sdREQ),  32'd1);
        check_val("hold_op",   32'(sdOP),   32'(e.op));
        check_val("hold_scan", 32'(sdSCAN), 32'(e.unit));
        rpSDOP[3*e.unit +: 3] = e.op;
        sdDONE = 1'b1;
        tick();
        sdDONE = 1'b0;
        oh = 8'h01 << e.unit;
        check_val("ack_req_low", 32'(sdREQ),   32'd0);
        check_val("ack_onehot",  32'(rpSDACK), 32'(oh));
        check_val("ack_busy",    32'(arbBUSY), 32'd1);
        if (drop) rpSDREQ[e.unit] = 1'b0;
        tick();
        check_val("ack_width", 32'(rpSDACK), 32'd0);
        if (drop) begin
            tick();
            nx = e.unit + 3'd1;
            check_val("rel_scan_state", 32'(arbBUSY), 32'd0);
            check_val("rel_scan_next",  32'(sdSCAN),  32'(nx));
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        clr    = 1'b0;
        sdDONE = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        grant_t e;
        bit     ok;
        int     rel;
        for (int n = 0; n < 8; n++) begin
            rpSDOP[3*n +: 3]    = 3'(n + 1);
            rpSDLSA[21*n +: 21] = 21'h100000 + 21'(n * 21'h1111);
        end

        // ---------------- single request, reset values, latency -------------
        rst = 1'b1;
        rpSDREQ = 8'h08;
        rpSDOP[9 +: 3]    = 3'd2;
        rpSDLSA[63 +: 21] = 21'h0ABCDE;
        tick();
        check_val("rst_req",  32'(sdREQ),   32'd0);
        check_val("rst_scan", 32'(sdSCAN),  32'd0);
        check_val("rst_op",   32'(sdOP),    32'd0);
        check_val("rst_lsa",  32'(sdLSA),   32'd0);
        check_val("rst_ack",  32'(rpSDACK), 32'd0);
        check_val("rst_busy", 32'(arbBUSY), 32'd0);
        check_val("rst_tmo",  32'(arbTMO),  32'd0);
        push_exp(3);
        rst = 1'b0;
        tick();
        tick();
        tick();
        check_val("lat_not_yet", 32'(sdREQ), 32'd0);
        tick();
        check_val("lat_4", 32'(sdREQ), 32'd1);
        serve(1'b1);

        // ---------------- round robin ----------------
        rpSDREQ = 8'hFF;
        do_reset();
        for (int n = 0; n < 8; n++) push_exp(n);
        push_exp(0);
        for (int n = 0; n < 8; n++) begin
            serve(1'b1);
            rpSDREQ[n] = 1'b1;
        end
        serve(1'b1);

        // ---------------- wrap from unit 6 ----------------
        rpSDREQ = 8'h00;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (sdSCAN == 3'd6) break;
            tick();
        end
        check_val("wrap_at6", 32'(sdSCAN), 32'd6);
        rpSDREQ = 8'h21;
        push_exp(0);
        push_exp(5);
        serve(1'b1);
        serve(1'b1);

        // ---------------- hold timeout ----------------
        rpSDREQ = 8'h14;
        do_reset();
        push_exp(2);
        push_exp(4);
        serve(1'b0);
        rel = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!arbBUSY) break;
            if (rel == 8) check_val("tmo_early", 32'(arbTMO), 32'd0);
            rel++;
        end
        check_val("tmo_dwell", 32'(rel), 32'(HOLDMAX + 1));
        check_val("tmo_set",   32'(arbTMO), 32'd1);
        check_val("tmo_scan",  32'(sdSCAN), 32'd3);
        serve(1'b1);
        check_val("tmo_sticky", 32'(arbTMO), 32'd1);
        rpSDREQ[2] = 1'b0;

        // ---------------- clr mid-operation ----------------
        rpSDREQ = 8'h20;
        push_exp(5);
        grab(e, ok);
        clr    = 1'b1;
        sdDONE = 1'b1;
        tick();
        clr    = 1'b0;
        sdDONE = 1'b0;
        rpSDREQ = 8'h00;
        check_val("clr_req",  32'(sdREQ),   32'd0);
        check_val("clr_scan", 32'(sdSCAN),  32'd0);
        check_val("clr_ack",  32'(rpSDACK), 32'd0);
        check_val("clr_busy", 32'(arbBUSY), 32'd0);
        check_val("clr_tmo",  32'(arbTMO),  32'd0);
        sdDONE = 1'b1;
        tick();
        sdDONE = 1'b0;
        check_val("stray_done_ack",  32'(rpSDACK), 32'd0);
        check_val("stray_done_busy", 32'(arbBUSY), 32'd0);
        tick();
        check_val("stray_done_ack2", 32'(rpSDACK), 32'd0);

        // ---------------- async reset during ACK ----------------
        rpSDREQ = 8'h02;
        do_reset();
        push_exp(1);
        grab(e, ok);
        sdDONE = 1'b1;
        tick();
        sdDONE = 1'b0;
        check_val("async_pre_ack", 32'(rpSDACK), 32'h02);
        #2;
        rst = 1'b1;
        #1;
        check_val("async_ack",  32'(rpSDACK), 32'd0);
        check_val("async_req",  32'(sdREQ),   32'd0);
        check_val("async_busy", 32'(arbBUSY), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rpSDREQ = 8'h00;

        check_val("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
